gemv_ctrl_axil_slave: RTL and testbench
=======================================

# gemv_ctrl_axil_slave

AXI4-Lite responder that terminates the S00_AXI_CTRL port of the gemv_float_q8 accelerator. It exposes four 32-bit control/status registers to the PS or AXI VIP master, and drives a start pulse plus configuration fields into the GEMV datapath. It also captures the datapath's done event as a sticky status bit. It is the slave end of the master write/read sequences used by the block-design bench.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte-address width; decode uses bits [3:2].
- ACLK  in  1  single clock for all logic.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake.
- gemv_start  out  1  one-cycle pulse to the datapath.
- gemv_cfg_m, gemv_cfg_n  out  16 each  matrix dimensions, from REG1[15:0] and REG1[31:16].
- gemv_cfg_base  out  32  operand base, from REG2.
- gemv_done  in  1  datapath completion pulse.

## Operation
- REG0 CTRL, offset 0x0:
  - [0] START: R/W storage bit.
  - [1] IE: R/W.
  - [30:2]: R/W scratch.
  - [31] DONE: read-only sticky bit. Writing 1 to bit 31 clears it.
- REG1 DIM (0x4), REG2 BASE (0x8) and REG3 SCRATCH (0xC) are plain R/W.
- Byte writes honour WSTRB per byte lane. A byte with its strobe bit low keeps its old value.
- gemv_start pulses for exactly one cycle when a committed write to REG0 has WSTRB[0]=1 and WDATA[0]=1. The stored START bit also takes the written value. Readback therefore returns what was written.
- DONE is set on a gemv_done pulse. If a W1C clear of DONE and gemv_done fall in the same cycle, set wins.
- All four offsets are mapped, and every response is OKAY.
- Reset values: all registers 0, all READY/VALID outputs 0, RDATA 0, gemv_start 0.

## Timing
- Write path:
  - Cycle N: AWVALID and WVALID both high, BVALID low, AWREADY low.
  - Cycle N+1: AWREADY and WREADY are both high for exactly one cycle; the register commits at the end of this cycle.
  - Cycle N+2: BVALID rises, and gemv_start pulses in this same cycle if triggered.
- AW arriving before W, or W before AW, is held (no READY) until both are valid.
- BVALID holds until BREADY. No new write is accepted while BVALID is high, so at most one write is outstanding.
- Read path:
  - Cycle N: ARVALID high, RVALID low.
  - Cycle N+1: ARREADY is high for one cycle and the address is latched.
  - Cycle N+2: RVALID rises with RDATA.
- RDATA is stable while RVALID is high and RREADY is low. No new AR is accepted until the R handshake completes.
- Read and write channels are independent and may be in flight concurrently. A read sampled in the same cycle a write commits to the same register returns the pre-write value.
- Reset asserted mid-transaction drops all VALID/READY signals immediately. No response is owed for the aborted transaction.

## Configuration
- GEMV_CTRL_IRQ_EN:
  - Defined: adds output irq (1 bit, registered) equal to REG0[31] & REG0[1]. The output reset value is 0.
  - Undefined: the irq port does not exist. IE remains a plain storage bit.

## Structure
- Shared package gemv_ctrl_pkg holds:
  - register offsets (GEMV_REG_CTRL=0, DIM=1, BASE=2, SCRATCH=3, as word indices);
  - CTRL bit-position constants;
  - a ctrl_reg_t packed struct.
- Single module with no sub-module. Write FSM, read FSM and register file are all in one module.

## Test plan
1. Write 0x1, 0x2, 0x3, 0x4 to offsets 0x0–0xC, then read them back in order. Required: reads return 0x1, 0x2, 0x3, 0x4, every BRESP/RRESP is OKAY, and gemv_start pulses once (first write).
2. Present AWVALID 3 cycles before WVALID at 0x8 with data 0xDEADBEEF. Required: no AWREADY until WVALID, BVALID 2 cycles after both are valid, readback 0xDEADBEEF.
3. Write 0xFFFFFFFF to 0xC with WSTRB=4'b0101 over an initial value 0. Required: readback 0x00FF00FF.
4. Pulse gemv_done, then read 0x0. Required: bit 31 set. Then write 0x80000000 in the same cycle as another gemv_done. Required: bit 31 still set. Then write 0x80000000 again. Required: bit 31 clear.
5. Complete a write, hold BREADY low for 10 cycles, and issue a second AW/W meanwhile. Required: BVALID stays high, second AWREADY only after the B handshake, both writes land.
6. Drop ARESETN while RVALID is high with RREADY low. Required: RVALID goes to 0 immediately and all registers read 0 after reset release.

Source files
------------

// File: rtl/gemv_ctrl_pkg.sv
// gemv_ctrl_pkg: register map, CTRL bit positions and the byte-strobe merge
// shared by the GEMV control AXI4-Lite slave.
package gemv_ctrl_pkg;

   // Word indices of the four control/status registers (byte address bits [3:2])
   localparam logic [1:0] GEMV_REG_CTRL    = 2'd0;
   localparam logic [1:0] GEMV_REG_DIM     = 2'd1;
   localparam logic [1:0] GEMV_REG_BASE    = 2'd2;
   localparam logic [1:0] GEMV_REG_SCRATCH = 2'd3;

   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_IE_BIT    = 1;
   localparam int CTRL_DONE_BIT  = 31;

   typedef struct packed {
      logic        done;
      logic [28:0] scratch;
      logic        ie;
      logic        start;
   } ctrl_reg_t;

   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] merged;
      merged = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/gemv_ctrl_axil_slave.sv
// AXI4-Lite slave for the gemv_float_q8 control port: four 32-bit registers, start pulse, sticky DONE.
// Optional build macro GEMV_CTRL_IRQ_EN adds a registered irq output (DONE & IE).
module gemv_ctrl_axil_slave
   import gemv_ctrl_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            gemv_start,
   output logic [15:0]                     gemv_cfg_m,
   output logic [15:0]                     gemv_cfg_n,
   output logic [31:0]                     gemv_cfg_base,
   input  logic                            gemv_done
`ifdef GEMV_CTRL_IRQ_EN
   ,
   output logic                            irq
`endif
);

   typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_RESP} wr_state_t;
   typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA}   rd_state_t;

   wr_state_t r_wr_state;
   rd_state_t r_rd_state;
   logic      r_awready, r_wready, r_bvalid, r_start;
   logic      r_arready, r_rvalid;
   logic [31:0] r_rdata;

   ctrl_reg_t   r_ctrl;
   logic [31:0] r_dim, r_base, r_scratch;

   ctrl_reg_t   w_ctrl_next;
   logic [31:0] w_rd_word;
   logic [1:0]  w_wr_idx, w_rd_idx;
   logic        w_wr_commit, w_start_hit;
   logic        w_unused_ok;

   assign w_wr_idx    = S_AXI_AWADDR[3:2];
   assign w_rd_idx    = S_AXI_ARADDR[3:2];
   assign w_wr_commit = (r_wr_state == WR_ACCEPT);
   assign w_start_hit = (w_wr_idx == GEMV_REG_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[CTRL_START_BIT];
   assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                          r_ctrl[CTRL_IE_BIT]};

   // Write channel: AW and W are only accepted together, and never while a response is pending.
   // NOTE: sequential state uses <= so every block samples pre-edge values; this is also
   // what makes a read latched in the commit cycle return the pre-write register contents.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_wr_state <= WR_IDLE;
         r_awready  <= 1'b0;
         r_wready   <= 1'b0;
         r_bvalid   <= 1'b0;
         r_start    <= 1'b0;
      end else begin
         r_start <= 1'b0;
         case (r_wr_state)
            WR_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) begin
               r_awready  <= 1'b1;
               r_wready   <= 1'b1;
               r_wr_state <= WR_ACCEPT;
            end
            WR_ACCEPT: begin
               r_awready  <= 1'b0;
               r_wready   <= 1'b0;
               r_bvalid   <= 1'b1;
               r_start    <= w_start_hit;
               r_wr_state <= WR_RESP;
            end
            WR_RESP: if (S_AXI_BREADY) begin
               r_bvalid   <= 1'b0;
               r_wr_state <= WR_IDLE;
            end
            default: r_wr_state <= WR_IDLE;
         endcase
      end
   end

   // DONE is read-only except for W1C; a same-cycle gemv_done overrides the clear.
   // NOTE: the default assignment first keeps this always_comb free of inferred latches.
   always_comb begin
      w_ctrl_next = r_ctrl;
      if (w_wr_commit && (w_wr_idx == GEMV_REG_CTRL)) begin
         w_ctrl_next      = ctrl_reg_t'(apply_wstrb(r_ctrl, S_AXI_WDATA, S_AXI_WSTRB));
         w_ctrl_next.done = r_ctrl.done;
         if (S_AXI_WSTRB[CTRL_DONE_BIT/8] && S_AXI_WDATA[CTRL_DONE_BIT]) w_ctrl_next.done = 1'b0;
      end
      if (gemv_done) w_ctrl_next.done = 1'b1;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_ctrl    <= '0;
         r_dim     <= '0;
         r_base    <= '0;
         r_scratch <= '0;
      end else begin
         r_ctrl <= w_ctrl_next;
         if (w_wr_commit) begin
            case (w_wr_idx)
               GEMV_REG_DIM:     r_dim     <= apply_wstrb(r_dim, S_AXI_WDATA, S_AXI_WSTRB);
               GEMV_REG_BASE:    r_base    <= apply_wstrb(r_base, S_AXI_WDATA, S_AXI_WSTRB);
               GEMV_REG_SCRATCH: r_scratch <= apply_wstrb(r_scratch, S_AXI_WDATA, S_AXI_WSTRB);
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      w_rd_word = r_scratch;
      case (w_rd_idx)
         GEMV_REG_CTRL: w_rd_word = r_ctrl;
         GEMV_REG_DIM:  w_rd_word = r_dim;
         GEMV_REG_BASE: w_rd_word = r_base;
         default:       w_rd_word = r_scratch;
      endcase
   end

   // Read channel: RDATA is captured once in the ARREADY cycle and held until RREADY.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_rd_state <= RD_IDLE;
         r_arready  <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rdata    <= '0;
      end else begin
         case (r_rd_state)
            RD_IDLE: if (S_AXI_ARVALID) begin
               r_arready  <= 1'b1;
               r_rd_state <= RD_ADDR;
            end
            RD_ADDR: begin
               r_arready  <= 1'b0;
               r_rvalid   <= 1'b1;
               r_rdata    <= w_rd_word;
               r_rd_state <= RD_DATA;
            end
            RD_DATA: if (S_AXI_RREADY) begin
               r_rvalid   <= 1'b0;
               r_rd_state <= RD_IDLE;
            end
            default: r_rd_state <= RD_IDLE;
         endcase
      end
   end

`ifdef GEMV_CTRL_IRQ_EN
   logic r_irq;
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) r_irq <= 1'b0;
      else          r_irq <= r_ctrl.done & r_ctrl.ie;
   end
   assign irq = r_irq;
`endif

   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_wready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = 2'b00;
   assign gemv_start    = r_start;
   assign gemv_cfg_m    = r_dim[15:0];
   assign gemv_cfg_n    = r_dim[31:16];
   assign gemv_cfg_base = r_base;

endmodule

// File: tb/tb_gemv_ctrl_axil_slave.sv
// Self-checking bench for gemv_ctrl_axil_slave: directed scenarios plus randomized
// register traffic compared against a behavioural register-map model.
module tb_gemv_ctrl_axil_slave;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [3:0]  S_AXI_AWADDR, S_AXI_ARADDR;
   logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
   logic        S_AXI_AWVALID, S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID, S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
   logic        S_AXI_BVALID, S_AXI_BREADY;
   logic        S_AXI_ARVALID, S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic        S_AXI_RVALID, S_AXI_RREADY;
   logic        gemv_start, gemv_done;
   logic [15:0] gemv_cfg_m, gemv_cfg_n;
   logic [31:0] gemv_cfg_base;

   gemv_ctrl_axil_slave dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .gemv_start(gemv_start), .gemv_cfg_m(gemv_cfg_m), .gemv_cfg_n(gemv_cfg_n),
      .gemv_cfg_base(gemv_cfg_base), .gemv_done(gemv_done)
   );

   always #5 ACLK = ~ACLK;

   int n_tests = 0;
   int n_fail  = 0;
   int start_count = 0;

   // Reference model: four words, with the sticky DONE flag kept apart from CTRL storage
   logic [31:0] model_regs [4];
   logic        model_done;

   always @(posedge ACLK) if (ARESETN && gemv_start) start_count++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
      model_done = 1'b0;
   endfunction

   function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] mask;
      logic [31:0] merged;
      for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{s[b]}};
      merged = (model_regs[idx] & ~mask) | (d & mask);
      if (idx == 0) begin
         model_regs[0] = {1'b0, merged[30:0]};
         if (s[3] && d[31]) model_done = 1'b0;
      end else begin
         model_regs[idx] = merged;
      end
   endfunction

   function automatic logic [31:0] model_read(input int idx);
      return (idx == 0) ? {model_done, model_regs[0][30:0]} : model_regs[idx];
   endfunction

   // lead > 0: AW presented that many cycles before W; lead < 0: W first.
   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead, input bit done_now);
      int  n;
      int  idx;
      bit  exp_start;
      idx = int'(addr[3:2]);
      exp_start = (idx == 0) && strb[0] && data[0];
      S_AXI_AWADDR = addr;
      S_AXI_WDATA  = data;
      S_AXI_WSTRB  = strb;
      S_AXI_BREADY = 1'b1;
      if (lead > 0) S_AXI_AWVALID = 1'b1;
      else if (lead < 0) S_AXI_WVALID = 1'b1;
      for (int i = 0; i < (lead < 0 ? -lead : lead); i++) begin
         @(negedge ACLK);
         check("wr_early_no_ready", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd0);
      end
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      n = 0;
      do begin
         @(negedge ACLK);
         n++;
      end while (!S_AXI_AWREADY && n < 20);
      check("wr_aw_latency", n, 1);
      check("wr_wready", S_AXI_WREADY, 1'b1);
      if (done_now) gemv_done = 1'b1;
      @(negedge ACLK);
      gemv_done = 1'b0;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      check("wr_bvalid", S_AXI_BVALID, 1'b1);
      check("wr_bresp", S_AXI_BRESP, 2'b00);
      check("wr_start", gemv_start, exp_start);
      model_write(idx, data, strb);
      if (done_now) model_done = 1'b1;
      @(negedge ACLK);
      check("wr_bvalid_drop", S_AXI_BVALID, 1'b0);
      check("wr_start_single", gemv_start, 1'b0);
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
      int n;
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = 1'b1;
      S_AXI_RREADY  = 1'b1;
      n = 0;
      do begin
         @(negedge ACLK);
         n++;
      end while (!S_AXI_ARREADY && n < 20);
      check("rd_ar_latency", n, 1);
      @(negedge ACLK);
      S_AXI_ARVALID = 1'b0;
      check("rd_rvalid", S_AXI_RVALID, 1'b1);
      check("rd_rresp", S_AXI_RRESP, 2'b00);
      data = S_AXI_RDATA;
      @(negedge ACLK);
      check("rd_rvalid_drop", S_AXI_RVALID, 1'b0);
   endtask

   task automatic read_check(input string tag, input int idx);
      logic [31:0] d;
      axi_read(4'(idx * 4), d);
      check(tag, d, model_read(idx));
   endtask

   task automatic pulse_done();
      @(negedge ACLK);
      gemv_done = 1'b1;
      @(negedge ACLK);
      gemv_done = 1'b0;
      model_done = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      int          s0, n;
      ARESETN = 1'b0;
      S_AXI_AWADDR = '0; S_AXI_ARADDR = '0; S_AXI_AWPROT = '0; S_AXI_ARPROT = '0;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
      S_AXI_BREADY = 1'b0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0; gemv_done = 1'b0;
      model_reset();
      repeat (3) @(negedge ACLK);
      check("rst_ready_valid", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
                                S_AXI_RVALID, gemv_start}, 6'd0);
      check("rst_rdata", S_AXI_RDATA, 32'h0);
      check("rst_cfg", {gemv_cfg_n, gemv_cfg_m}, 32'h0);
      ARESETN = 1'b1;
      @(negedge ACLK);

      // Basic write / readback, single start pulse
      s0 = start_count;
      for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         axi_read(4'(i * 4), d);
         check("basic_readback", d, 32'(i + 1));
      end
      check("basic_start_count", start_count - s0, 1);
      check("cfg_dims", {gemv_cfg_n, gemv_cfg_m}, 32'h2);
      check("cfg_base", gemv_cfg_base, 32'h3);

      // AW three cycles ahead of W
      axi_write(4'h8, 32'hDEADBEEF, 4'hF, 3, 1'b0);
      read_check("aw_early_readback", 2);
      axi_write(4'h4, 32'h0012_0034, 4'hF, -2, 1'b0);
      read_check("w_early_readback", 1);

      // Partial byte strobes
      axi_write(4'hC, 32'h0, 4'hF, 0, 1'b0);
      axi_write(4'hC, 32'hFFFFFFFF, 4'b0101, 0, 1'b0);
      axi_read(4'hC, d);
      check("strb_readback", d, 32'h00FF00FF);

      // Sticky DONE, set-wins collision, then W1C
      pulse_done();
      axi_read(4'h0, d);
      check("done_set", d[31], 1'b1);
      axi_write(4'h0, 32'h80000000, 4'hF, 0, 1'b1);
      axi_read(4'h0, d);
      check("done_set_wins", d[31], 1'b1);
      axi_write(4'h0, 32'h80000000, 4'hF, 0, 1'b0);
      axi_read(4'h0, d);
      check("done_w1c", d[31], 1'b0);

      // Back-pressured B channel with a second write queued behind it
      S_AXI_BREADY = 1'b0;
      S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'hA5A5_0001; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      n = 0;
      do begin @(negedge ACLK); n++; end while (!S_AXI_AWREADY && n < 20);
      check("bp_first_ready", S_AXI_AWREADY, 1'b1);
      @(negedge ACLK);
      model_write(1, 32'hA5A5_0001, 4'hF);
      S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'h5A5A_0002;
      for (int i = 0; i < 10; i++) begin
         check("bp_bvalid_hold", S_AXI_BVALID, 1'b1);
         check("bp_no_second_ready", S_AXI_AWREADY, 1'b0);
         @(negedge ACLK);
      end
      S_AXI_BREADY = 1'b1;
      @(negedge ACLK);
      check("bp_b_done", S_AXI_BVALID, 1'b0);
      check("bp_ready_after_b", S_AXI_AWREADY, 1'b0);
      n = 0;
      do begin @(negedge ACLK); n++; end while (!S_AXI_AWREADY && n < 20);
      check("bp_second_latency", n, 1);
      @(negedge ACLK);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      model_write(2, 32'h5A5A_0002, 4'hF);
      check("bp_second_bvalid", S_AXI_BVALID, 1'b1);
      @(negedge ACLK);
      read_check("bp_first_lands", 1);
      read_check("bp_second_lands", 2);

      // Randomized traffic against the model
      for (int k = 0; k < 60; k++) begin
         int op, idx;
         op  = int'($urandom_range(0, 9));
         idx = int'($urandom_range(0, 3));
         if (op < 5) axi_write(4'(idx * 4), $urandom, 4'($urandom_range(0, 15)),
                               int'($urandom_range(0, 4)) - 2, ($urandom_range(0, 7) == 0));
         else if (op < 9) read_check("rand_read", idx);
         else pulse_done();
      end
      check("rand_cfg_m", gemv_cfg_m, model_regs[1][15:0]);
      check("rand_cfg_n", gemv_cfg_n, model_regs[1][31:16]);
      check("rand_cfg_base", gemv_cfg_base, model_regs[2]);

      // Reset while a read response is stalled
      S_AXI_ARADDR = 4'hC; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
      n = 0;
      do begin @(negedge ACLK); n++; end while (!S_AXI_ARREADY && n < 20);
      @(negedge ACLK);
      S_AXI_ARVALID = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("stall_rvalid", S_AXI_RVALID, 1'b1);
         check("stall_rdata", S_AXI_RDATA, model_read(3));
         @(negedge ACLK);
      end
      ARESETN = 1'b0;
      #1;
      check("rst_mid_rvalid", S_AXI_RVALID, 1'b0);
      check("rst_mid_others", {S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_BVALID}, 3'd0);
      model_reset();
      repeat (2) @(negedge ACLK);
      ARESETN = 1'b1;
      @(negedge ACLK);
      for (int i = 0; i < 4; i++) read_check("post_reset_zero", i);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
